// File: rtl/uart_tx_cfg_pkg.sv
// Shared definitions for the configurable UART transmitter:
// FSM encoding, parity codes, data-length limits and width helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [3:0] MIN_DBITS = 4'd5;

  // Ceiling log2 with a floor of one bit so single-value counters stay legal.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  // Requested data length limited to the range the shifter can hold.
  function automatic logic [3:0] clampDbits(input logic [3:0] reqBits,
                                            input logic [3:0] maxBits);
    if (reqBits < MIN_DBITS) return MIN_DBITS;
    if (reqBits > maxBits) return maxBits;
    return reqBits;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Valid/ready word interface feeding the UART transmitter.
interface uart_tx_cfg_if #(parameter int DW = 8);

  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);

endinterface

// File: rtl/uart_tx_cfg_holdbuf.sv
// One-entry holding register between the producer handshake and the shifter.
module uart_tx_holdbuf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_cfg_if.slave  bus,
  input  logic          i_load,
  output logic          o_full,
  output logic [DW-1:0] o_data
);

  logic          r_full;
  logic [DW-1:0] r_data;
  logic          w_accept;

  // Only an empty buffer accepts, so accept and load are mutually exclusive.
  assign w_accept = bus.din_valid & ~r_full;

  // Capture a word on handshake; drop it once the shifter has taken it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_data <= bus.din;
    end else if (i_load) begin
      r_full <= 1'b0;
    end
  end

  assign bus.din_ready = ~r_full;
  assign o_full        = r_full;
  assign o_data        = r_data;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..DW data bits, optional even/odd parity,
// one or two stop bits, OS ticks per bit, back-to-back frames via holdbuf.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DW = 8,
  parameter int OS = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_tick,
  uart_tx_cfg_if.slave bus,
  input  logic [3:0]   cfg_dbits,
  input  logic [1:0]   cfg_parity,
  input  logic         cfg_stop2,
  output logic         tx,
  output logic         tx_busy,
  output logic         tx_done
);

  localparam int            SW      = clog2(OS);
  localparam int            NW      = clog2(DW);
  localparam logic [SW-1:0] S_LAST  = SW'(OS - 1);
  localparam logic [3:0]    DW_BITS = 4'(DW);

  txState_t      r_state;
  txState_t      w_stateNext;
  logic [SW-1:0] r_s;
  logic [NW-1:0] r_n;
  logic          r_stopCnt;
  logic [DW-1:0] r_shift;
  logic [3:0]    r_dbits;
  logic          r_parEn;
  logic          r_parBit;
  logic          r_stop2;
  logic          r_tx;

  logic          w_full;
  logic          w_load;
  logic [DW-1:0] w_bufData;
  logic [DW-1:0] w_mask;
  logic [3:0]    w_dbitsClamped;
  logic          w_parEven;
  logic          w_parOdd;
  logic          w_parCalc;
  logic          w_bitEnd;
  logic          w_lastData;
  logic          w_lastStop;
  logic          w_txLevel;
  logic          w_txDone;

  uart_tx_holdbuf #(.DW(DW)) u_holdbuf (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .i_load (w_load),
    .o_full (w_full),
    .o_data (w_bufData)
  );

  assign w_dbitsClamped = clampDbits(cfg_dbits, DW_BITS);
  assign w_parEven      = (cfg_parity == PAR_EVEN);
  assign w_parOdd       = (cfg_parity == PAR_ODD);
  assign w_parCalc      = ^(w_bufData & w_mask);
  assign w_bitEnd       = s_tick & (r_s == S_LAST);
  assign w_lastData     = (r_n == NW'(r_dbits - 4'd1));
  assign w_lastStop     = ~r_stop2 | r_stopCnt;

  // Mask off buffer bits beyond the clamped length so parity only sees sent bits.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DW; i++) begin
      w_mask[i] = (i < int'(w_dbitsClamped));
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Next state, line level, shifter load request and end-of-frame pulse.
  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_txLevel   = 1'b1;
    w_txDone    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_full) begin
          w_load      = 1'b1;
          w_stateNext = START;
        end
      end
      START: begin
        w_txLevel = 1'b0;
        if (w_bitEnd) w_stateNext = DATA;
      end
      DATA: begin
        w_txLevel = r_shift[0];
        if (w_bitEnd && w_lastData) w_stateNext = r_parEn ? PARITY : STOP;
      end
      PARITY: begin
        w_txLevel = r_parBit;
        if (w_bitEnd) w_stateNext = STOP;
      end
      STOP: begin
        if (w_bitEnd && w_lastStop) begin
          w_txDone = 1'b1;
          if (w_full) begin
            w_load      = 1'b1;
            w_stateNext = START;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Tick counter stays parked at zero in IDLE and wraps at every bit end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s       <= '0;
      r_stopCnt <= 1'b0;
    end else begin
      if (r_state != IDLE && s_tick) r_s <= w_bitEnd ? '0 : r_s + SW'(1);
      if (r_state == STOP && w_bitEnd) r_stopCnt <= r_stop2 & ~r_stopCnt;
    end
  end

  // Shifter and per-frame configuration are captured together at load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift  <= '0;
      r_n      <= '0;
      r_dbits  <= MIN_DBITS;
      r_parEn  <= 1'b0;
      r_parBit <= 1'b0;
      r_stop2  <= 1'b0;
    end else if (w_load) begin
      r_shift  <= w_bufData;
      r_n      <= '0;
      r_dbits  <= w_dbitsClamped;
      r_parEn  <= w_parEven | w_parOdd;
      r_parBit <= w_parOdd ? ~w_parCalc : w_parCalc;
      r_stop2  <= cfg_stop2;
    end else if (r_state == DATA && w_bitEnd) begin
      r_shift <= r_shift >> 1;
      r_n     <= w_lastData ? '0 : r_n + NW'(1);
    end
  end

  // Registered line driver keeps the pin glitch-free; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_tx <= 1'b1;
    else       r_tx <= w_txLevel;
  end

  assign tx      = r_tx;
  assign tx_busy = (r_state != IDLE);
  assign tx_done = w_txDone;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: every clk is checked against a frame model built
// from bit lists and tick arithmetic (bit index = ticks elapsed / OS).
module tb_uart_tx_cfg;

  localparam int DW          = 8;
  localparam int OS          = 16;
  localparam int CYCLE_LIMIT = 20000;

  typedef bit bitQ_t[$];

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic [3:0] cfg_dbits;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int  checkCount;
  int  passCount;
  int  failCount;
  int  tickMode;
  bit  modelFull;

  bitQ_t      frameA;
  bitQ_t      frameB;
  logic [7:0] rData;
  logic [3:0] rBits;
  logic [1:0] rPar;
  logic       rStop;

  uart_tx_cfg_if #(.DW(DW)) bus();

  uart_tx_cfg #(.DW(DW), .OS(OS)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_tick     (s_tick),
    .bus        (bus),
    .cfg_dbits  (cfg_dbits),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // s_tick changes shortly after each rising edge: always high or random.
  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      s_tick = (tickMode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected line levels of one frame, one entry per OS-tick bit slot.
  function automatic bitQ_t buildFrame(input logic [7:0] data, input logic [3:0] reqBits,
                                       input logic [1:0] parity, input logic stop2);
    bitQ_t q;
    int    nBits;
    int    ones;
    nBits = (reqBits < 5) ? 5 : ((int'(reqBits) > DW) ? DW : int'(reqBits));
    ones  = 0;
    q.push_back(1'b0);
    for (int i = 0; i < nBits; i++) begin
      q.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (parity == 2'b01) q.push_back(bit'(ones % 2 == 1));
    else if (parity == 2'b10) q.push_back(bit'(ones % 2 == 0));
    q.push_back(1'b1);
    if (stop2) q.push_back(1'b1);
    return q;
  endfunction

  // Hands a word over and returns at the negedge of the first busy cycle.
  task automatic applyStimulus(input logic [7:0] data, input logic [3:0] reqBits,
                               input logic [1:0] parity, input logic stop2);
    int waitCount;
    cfg_dbits     = reqBits;
    cfg_parity    = parity;
    cfg_stop2     = stop2;
    bus.din       = data;
    bus.din_valid = 1'b1;
    waitCount     = 0;
    while (bus.din_ready !== 1'b1 && waitCount < 50) begin
      @(negedge clk);
      waitCount++;
    end
    checkOutput("ready_before_accept", bus.din_ready, 1);
    @(negedge clk);
    bus.din_valid = 1'b0;
    checkOutput("ready_after_accept", bus.din_ready, 0);
    checkOutput("busy_before_load", tx_busy, 0);
    @(negedge clk);
  endtask

  // Checks every clk of a frame; optionally offers the next word mid-frame.
  task automatic runFrame(input bitQ_t bits, input bit inject, input int injectAt,
                          input logic [7:0] injData, input logic [3:0] injBits,
                          input logic [1:0] injPar, input logic injStop2);
    int total;
    int ticks;
    int k;
    int prevBit;
    int doneCount;
    bit pending;
    total     = bits.size() * OS;
    ticks     = 0;
    k         = 0;
    prevBit   = 0;
    doneCount = 0;
    pending   = 1'b0;
    modelFull = 1'b0;
    while (ticks < total && k < CYCLE_LIMIT) begin
      if (pending) begin
        bus.din_valid = 1'b0;
        modelFull     = 1'b1;
        pending       = 1'b0;
      end
      checkOutput($sformatf("tx[%0d]", k), tx, (k == 0) ? 32'd1 : 32'(bits[prevBit]));
      checkOutput($sformatf("busy[%0d]", k), tx_busy, 1);
      checkOutput($sformatf("done[%0d]", k), tx_done, 32'(s_tick && (ticks + 1 == total)));
      checkOutput($sformatf("ready[%0d]", k), bus.din_ready, 32'(!modelFull));
      if (inject && k == injectAt) begin
        bus.din       = injData;
        bus.din_valid = 1'b1;
        cfg_dbits     = injBits;
        cfg_parity    = injPar;
        cfg_stop2     = injStop2;
      end
      if (bus.din_valid && bus.din_ready) pending = 1'b1;
      if (tx_done) doneCount++;
      prevBit = ticks / OS;
      if (s_tick) ticks++;
      @(negedge clk);
      k++;
    end
    if (ticks < total) checkOutput("frame_timeout", ticks, total);
    checkOutput("done_pulses", doneCount, 1);
  endtask

  task automatic checkIdle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      checkOutput("idle_tx", tx, 1);
      checkOutput("idle_busy", tx_busy, 0);
      checkOutput("idle_done", tx_done, 0);
      checkOutput("idle_ready", bus.din_ready, 1);
      @(negedge clk);
    end
  endtask

  initial begin
    checkCount    = 0;
    passCount     = 0;
    failCount     = 0;
    tickMode      = 0;
    modelFull     = 1'b0;
    reset         = 1'b1;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    cfg_dbits     = 4'd8;
    cfg_parity    = 2'b00;
    cfg_stop2     = 1'b0;

    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_busy", tx_busy, 0);
    checkOutput("rst_done", tx_done, 0);
    checkOutput("rst_ready", bus.din_ready, 1);
    reset = 1'b0;
    @(negedge clk);
    checkIdle(4);

    $display("[TB] 8N1 0x55");
    frameA = buildFrame(8'h55, 4'd8, 2'b00, 1'b0);
    applyStimulus(8'h55, 4'd8, 2'b00, 1'b0);
    runFrame(frameA, 1'b0, 0, 8'h00, 4'd0, 2'b00, 1'b0);
    checkIdle(3);

    $display("[TB] 7E2 0x41");
    frameA = buildFrame(8'h41, 4'd7, 2'b01, 1'b1);
    applyStimulus(8'h41, 4'd7, 2'b01, 1'b1);
    runFrame(frameA, 1'b0, 0, 8'h00, 4'd0, 2'b00, 1'b0);
    checkIdle(3);

    $display("[TB] 8O1 and 8E1 0xFF");
    frameA = buildFrame(8'hFF, 4'd8, 2'b10, 1'b0);
    applyStimulus(8'hFF, 4'd8, 2'b10, 1'b0);
    runFrame(frameA, 1'b0, 0, 8'h00, 4'd0, 2'b00, 1'b0);
    checkIdle(3);
    frameA = buildFrame(8'hFF, 4'd8, 2'b01, 1'b0);
    applyStimulus(8'hFF, 4'd8, 2'b01, 1'b0);
    runFrame(frameA, 1'b0, 0, 8'h00, 4'd0, 2'b00, 1'b0);
    checkIdle(3);

    $display("[TB] back-to-back 0xA5 then 0x3C with config change mid-frame");
    frameA = buildFrame(8'hA5, 4'd8, 2'b00, 1'b0);
    frameB = buildFrame(8'h3C, 4'd6, 2'b01, 1'b1);
    applyStimulus(8'hA5, 4'd8, 2'b00, 1'b0);
    runFrame(frameA, 1'b1, 3 * OS, 8'h3C, 4'd6, 2'b01, 1'b1);
    runFrame(frameB, 1'b0, 0, 8'h00, 4'd0, 2'b00, 1'b0);
    checkIdle(3);

    $display("[TB] data length clamping");
    frameA = buildFrame(8'hFF, 4'd2, 2'b11, 1'b0);
    applyStimulus(8'hFF, 4'd2, 2'b11, 1'b0);
    runFrame(frameA, 1'b0, 0, 8'h00, 4'd0, 2'b00, 1'b0);
    checkIdle(3);
    frameA = buildFrame(8'hB6, 4'd15, 2'b00, 1'b0);
    applyStimulus(8'hB6, 4'd15, 2'b00, 1'b0);
    runFrame(frameA, 1'b0, 0, 8'h00, 4'd0, 2'b00, 1'b0);
    checkIdle(3);

    $display("[TB] reset during DATA");
    applyStimulus(8'h33, 4'd8, 2'b00, 1'b0);
    repeat (4 * OS) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midrst_tx", tx, 1);
    checkOutput("midrst_busy", tx_busy, 0);
    checkOutput("midrst_ready", bus.din_ready, 1);
    checkOutput("midrst_done", tx_done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("inrst_tx", tx, 1);
      checkOutput("inrst_done", tx_done, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    checkIdle(2 * OS);
    frameA = buildFrame(8'h0F, 4'd8, 2'b00, 1'b0);
    applyStimulus(8'h0F, 4'd8, 2'b00, 1'b0);
    runFrame(frameA, 1'b0, 0, 8'h00, 4'd0, 2'b00, 1'b0);
    checkIdle(3);

    $display("[TB] random frames with sparse s_tick");
    tickMode = 1;
    for (int i = 0; i < 6; i++) begin
      rData  = 8'($urandom);
      rBits  = 4'($urandom_range(0, 15));
      rPar   = 2'($urandom_range(0, 3));
      rStop  = 1'($urandom_range(0, 1));
      frameA = buildFrame(rData, rBits, rPar, rStop);
      applyStimulus(rData, rBits, rPar, rStop);
      cfg_dbits  = 4'($urandom);
      cfg_parity = 2'($urandom);
      cfg_stop2  = 1'($urandom);
      runFrame(frameA, 1'b0, 0, 8'h00, 4'd0, 2'b00, 1'b0);
      checkIdle(3);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter in the UART path. It adds runtime-selectable data length, parity and stop-bit count, a configurable oversampling ratio, and a one-entry holding buffer with a valid/ready handshake so frames can go out back-to-back with no idle gap. It sits between the CORDIC result formatter and the board TX pin and consumes the shared baud-tick generator's s_tick.

Parameters:
DW, 8, width of din; maximum data bits per frame (5..9).
OS, 16, s_tick pulses per bit period (>=2); also the tick count of one stop bit.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
s_tick  in  1  oversampling tick, one clk wide.
din  in  DW  byte/word to send, LSB first.
din_valid  in  1  din is valid.
din_ready  out  1  holding buffer empty; a transfer occurs when din_valid && din_ready at posedge clk.
cfg_dbits  in  4  data bits per frame; values below 5 clamp to 5, values above DW clamp to DW.
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none.
cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits.
tx  out  1  serial line, registered, idles high.
tx_busy  out  1  high whenever the FSM is not in IDLE.
tx_done  out  1  one-clk pulse at the end of each frame's last stop bit.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- Reset values: tx=1, tx_busy=0, tx_done=0, din_ready=1, holding buffer empty, FSM in IDLE, all counters 0.
- Holding buffer:
  - Captures din on a transfer; din_ready goes low the next cycle.
  - The buffer empties when its contents load into the shifter; din_ready returns high the following cycle.
  - An accept and a load never occur in the same cycle.
- Frame start:
  - In IDLE with the buffer full, the next clk loads the shifter, latches cfg_dbits, cfg_parity and cfg_stop2, computes parity over the clamped data bits, and enters START.
  - Config changes during a frame have no effect until the next load.
- FSM states: IDLE, START, DATA, PARITY, STOP. The tick counter s advances only on s_tick. A bit ends on the s_tick where s==OS-1; that tick clears s.
  - START: line level 0. After OS ticks, go to DATA with n=0.
  - DATA: line level = shifter[0]. At each bit end, shift right. When n==dbits-1, go to PARITY if parity is enabled, else STOP; otherwise n++.
  - PARITY: line level = even ? ^data : ~^data. Lasts OS ticks, then STOP.
  - STOP: line level 1. Lasts OS ticks, or 2*OS ticks when stop2 is set; a stop-bit counter distinguishes the two.
  - Final stop tick: tx_done=1 for that clk. Next state is START if the buffer is full (back-to-back: load and config latch happen on this same edge), else IDLE.
- tx is registered from the current state's line level and therefore lags the state register by one clk. Frame length is (1+dbits+p+stopbits)*OS ticks.
- tx_busy is combinational from state != IDLE.
- Reset mid-frame: tx goes to 1 immediately (asynchronous), the buffer is dropped, tx_done is not issued, and no partial frame resumes.
- s_tick held high every clk must work; each bit then lasts exactly OS clks.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding (IDLE..STOP, 3 bits);
  - parity codes PAR_NONE/PAR_EVEN/PAR_ODD;
  - constants MIN_DBITS=5 and the clog2 helper used for the s and n counter widths.
- One natural sub-module: uart_tx_holdbuf, the one-entry valid/ready register with its load/accept logic. The FSM and datapath stay in uart_tx_cfg.

Test Plan:
- OS=16, 8N1, s_tick every clk, send 0x55 → tx sequence 0,1,0,1,0,1,0,1,0,1, each bit exactly 16 clks; tx_done pulses once at clk 160 after START entry; tx_busy drops the next clk.
- 7E2, send 0x41 → seven data bits 1,0,0,0,0,0,1; parity 0; two stop bits (32 ticks); total frame 11*16 ticks.
- 8O1, send 0xFF → eight 1s, parity bit 1. Then 8E1 with 0xFF → parity bit 0.
- Back-to-back: send 0xA5, then 0x3C while the first is in DATA (din_ready low until the first load clears) → second START begins on the clk after tx_done with no high idle gap; exactly two tx_done pulses.
- cfg_dbits=2 with din=0xFF → 5 data bits sent. cfg_dbits=15 → DW (8) bits sent.
- Assert reset midway through DATA of 0x33 → tx=1 within the same clk, tx_busy=0, din_ready=1, no tx_done. After release, a new 0x0F transmits correctly.
